// File: rtl/tile_seq_ctrl.sv
// Tile sequencer: decodes the full-type code into loop counts and steps the
// C-load / A-load / B-load / systolic / accumulate / write-back loop, with the
// next B column-block prefetched into the idle buffer while the array computes.
module tile_seq_ctrl #(
  parameter int unsigned PE_ROWS    = 8,
  parameter int unsigned PE_COLS    = 16,
  parameter int unsigned K_DIM      = 16,
  parameter int unsigned PIPE_LAT   = 2,
  parameter int unsigned ACC_CYCLES = 2,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       cfg_type,
  output logic             c_req,
  input  logic             c_done,
  output logic             a_req,
  input  logic             a_done,
  output logic             b_req,
  input  logic             b_done,
  output logic             d_req,
  input  logic             d_done,
  output logic             sys_en,
  output logic             acc_en,
  output logic             b_buf,
  output logic [2:0]       pattern,
  output logic [CNT_W-1:0] a_idx,
  output logic [CNT_W-1:0] b_idx,
  output logic [2:0]       state_o,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int unsigned L_SYS = K_DIM + PE_ROWS + PE_COLS - 2 + PIPE_LAT;
  localparam int unsigned CYC_W = 16;
  localparam logic [CYC_W-1:0] SYS_LAST = CYC_W'(L_SYS - 1);
  localparam logic [CYC_W-1:0] ACC_LAST = CYC_W'(ACC_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StReadC      = 3'd1,
    StSystolic   = 3'd2,
    StAccumulate = 3'd3,
    StWaitA      = 3'd4,
    StWaitB      = 3'd5,
    StWaitC      = 3'd6,
    StFinish     = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] a_idx_q, a_idx_d, b_idx_q, b_idx_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic             is_int_q, is_int_d;
  logic [2:0]       pattern_q, pattern_d;
  logic             pf_q, pf_d, b_buf_q, b_buf_d;
  logic             c_req_q, c_req_d, a_req_q, a_req_d, b_req_q, b_req_d, d_req_q, d_req_d;
  logic             sys_en_q, sys_en_d, acc_en_q, acc_en_d;
  logic             busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

  logic             cfg_legal, new_is_int;
  logic [1:0]       shape, prec;
  int unsigned      dim_m, dim_n;
  logic [CNT_W-1:0] new_cnt_a, new_cnt_b;
  logic             need_pf, sys_first, pf_phase_q, pf_phase_d;

  // Decode the requested full-type code into loop counts and precision class.
  always_comb begin
    cfg_legal  = (cfg_type < 4'd12);
    prec       = 2'(cfg_type / 4'd3);
    shape      = 2'(cfg_type % 4'd3);
    new_is_int = (prec >= 2'd2);
    case (shape)
      2'd0:    begin dim_m = 16; dim_n = 16; end
      2'd1:    begin dim_m = 8;  dim_n = 32; end
      default: begin dim_m = 32; dim_n = 8;  end
    endcase
    new_cnt_a = CNT_W'((dim_m + PE_ROWS - 1) / PE_ROWS);
    new_cnt_b = CNT_W'((dim_n + PE_COLS - 1) / PE_COLS);
  end

  // Next-state, loop indices, prefetch bookkeeping and registered outputs.
  always_comb begin
    state_d   = state_q;
    a_idx_d   = a_idx_q;
    b_idx_d   = b_idx_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    is_int_d  = is_int_q;
    pattern_d = pattern_q;
    pf_d      = pf_q;
    b_buf_d   = b_buf_q;

    case (state_q)
      StIdle: begin
        if (start && cfg_legal) begin
          state_d   = StReadC;
          cnt_a_d   = new_cnt_a;
          cnt_b_d   = new_cnt_b;
          is_int_d  = new_is_int;
          pattern_d = {2'b00, new_is_int};
          a_idx_d   = '0;
          b_idx_d   = '0;
          b_buf_d   = 1'b0;
          pf_d      = 1'b0;
        end
      end
      StReadC: if (c_req_q && c_done) state_d = StWaitA;
      StWaitA: if (a_req_q && a_done) state_d = StWaitB;
      StWaitB: begin
        if (pf_q) begin
          // Prefetched block is already in the idle buffer: just swap.
          pf_d    = 1'b0;
          b_buf_d = ~b_buf_q;
          state_d = StSystolic;
        end else if (b_req_q && b_done) begin
          state_d = StSystolic;
        end
      end
      StSystolic: if (cyc_q == SYS_LAST) state_d = is_int_q ? StAccumulate : StWaitC;
      StAccumulate: if (cyc_q == ACC_LAST) state_d = StWaitC;
      StWaitC: begin
        if (d_req_q && d_done) begin
          if (b_idx_q < cnt_b_q - 1'b1) begin
            b_idx_d = b_idx_q + 1'b1;
            state_d = StWaitB;
          end else if (a_idx_q < cnt_a_q - 1'b1) begin
            a_idx_d = a_idx_q + 1'b1;
            b_idx_d = '0;
            state_d = StReadC;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // A prefetch may complete any time from SYSTOLIC up to the end of WAIT_C.
    pf_phase_q = state_q inside {StSystolic, StAccumulate, StWaitC};
    pf_phase_d = state_d inside {StSystolic, StAccumulate, StWaitC};
    if (b_req_q && b_done && pf_phase_q) pf_d = 1'b1;

    need_pf   = (b_idx_q < cnt_b_q - 1'b1);
    sys_first = (state_d == StSystolic) && (state_q != StSystolic);

    // Handshake reqs rise on the second cycle of their state and fall with the exit.
    c_req_d = (state_d == StReadC) && (state_q == StReadC);
    a_req_d = (state_d == StWaitA) && (state_q == StWaitA);
    d_req_d = (state_d == StWaitC) && (state_q == StWaitC);
    b_req_d = 1'b0;
    if (state_d == StWaitB) begin
      b_req_d = (state_q == StWaitB);
    end else if (pf_phase_d) begin
      // Prefetch starts on the first array cycle and holds until acknowledged.
      b_req_d = need_pf && !pf_d &&
                (sys_first || (b_req_q && pf_phase_q && !(b_req_q && b_done)));
    end

    cyc_d = '0;
    if ((state_d == state_q) && (state_q inside {StSystolic, StAccumulate})) begin
      cyc_d = cyc_q + 1'b1;
    end

    sys_en_d  = (state_d == StSystolic);
    acc_en_d  = (state_d == StAccumulate);
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StFinish);
    cfg_err_d = (state_q == StIdle) && start && !cfg_legal;
  end

  // State and output registers; reset drops everything including latched config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cyc_q     <= '0;
      a_idx_q   <= '0;
      b_idx_q   <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      is_int_q  <= 1'b0;
      pattern_q <= '0;
      pf_q      <= 1'b0;
      b_buf_q   <= 1'b0;
      c_req_q   <= 1'b0;
      a_req_q   <= 1'b0;
      b_req_q   <= 1'b0;
      d_req_q   <= 1'b0;
      sys_en_q  <= 1'b0;
      acc_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      a_idx_q   <= a_idx_d;
      b_idx_q   <= b_idx_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      is_int_q  <= is_int_d;
      pattern_q <= pattern_d;
      pf_q      <= pf_d;
      b_buf_q   <= b_buf_d;
      c_req_q   <= c_req_d;
      a_req_q   <= a_req_d;
      b_req_q   <= b_req_d;
      d_req_q   <= d_req_d;
      sys_en_q  <= sys_en_d;
      acc_en_q  <= acc_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign state_o = state_q;
  assign a_idx   = a_idx_q;
  assign b_idx   = b_idx_q;
  assign pattern = pattern_q;
  assign b_buf   = b_buf_q;
  assign c_req   = c_req_q;
  assign a_req   = a_req_q;
  assign b_req   = b_req_q;
  assign d_req   = d_req_q;
  assign sys_en  = sys_en_q;
  assign acc_en  = acc_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule
